// File: rtl/word_chunk_serializer_if.sv
// Handshake bundle for the word-to-chunk serializer: word input side,
// chunk output side, abort and status.
interface word_chunk_serializer_if #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 8
);
    localparam int NCHUNK = (IN_W + OUT_W - 1) / OUT_W;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic [IW-1:0]    out_idx;
    logic             abort;
    logic             busy;

    // Environment side: supplies words, consumes chunks, may abort.
    modport master (
        output in_valid, in_data, out_ready, abort,
        input  in_ready, out_valid, out_data, out_last, out_idx, busy
    );

    // Serializer side.
    modport slave (
        input  in_valid, in_data, out_ready, abort,
        output in_ready, out_valid, out_data, out_last, out_idx, busy
    );
endinterface

// File: rtl/word_chunk_serializer.sv
// Width-down converter: latches one IN_W-bit word and presents it as
// NCHUNK registered OUT_W-bit chunks with valid/ready on both sides.
// A new word may load on the same edge the last chunk leaves, so
// consecutive words stream without a bubble.
module word_chunk_serializer #(
    parameter int IN_W       = 18,
    parameter int OUT_W      = 8,
    parameter int MSB_FIRST  = 0,
    parameter int LAST_ALIGN = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    word_chunk_serializer_if.slave  bus
);
    localparam int NCHUNK = (IN_W + OUT_W - 1) / OUT_W;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PW     = NCHUNK * OUT_W;
    localparam int REM    = IN_W % OUT_W;
    // Left-justifying the partial top chunk moves its REM bits to the MSBs.
    localparam int SHIFT  = (REM == 0) ? 0 : (OUT_W - REM);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

    state_t           r_state;
    logic [PW-1:0]    r_word;
    logic [IW-1:0]    r_idx;
    logic [OUT_W-1:0] r_data;
    logic             r_last;
    logic             r_valid;

    logic [PW-1:0]    w_pad;
    logic [IW-1:0]    w_next_idx;
    logic             w_xfer;
    logic             w_in_ready;
    logic             w_accept;

    // Select emission-order chunk k from a zero-padded word, applying
    // the chunk order and the placement of the partial top chunk.
    function automatic logic [OUT_W-1:0] f_chunk(input logic [PW-1:0] word,
                                                 input logic [IW-1:0] k);
        int               p;
        logic [OUT_W-1:0] c;
        p = (MSB_FIRST != 0) ? (NCHUNK - 1 - int'(k)) : int'(k);
        c = word[p*OUT_W +: OUT_W];
        if ((REM != 0) && (LAST_ALIGN != 0) && (p == NCHUNK - 1)) begin
            c = c << SHIFT;
        end
        return c;
    endfunction

    // Zero-extend the incoming word to a whole number of chunks.
    always_comb begin
        w_pad             = '0;
        w_pad[IN_W-1:0]   = bus.in_data;
    end

    assign w_next_idx = r_idx + IW'(1);
    assign w_xfer     = r_valid && bus.out_ready;
    // Ready while idle, or on the edge the final chunk leaves (unless aborting).
    assign w_in_ready = !r_valid || (w_xfer && r_last && !bus.abort);
    assign w_accept   = bus.in_valid && w_in_ready;

    // Serializer FSM: load on accept, advance on transfer, drop on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_word  <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_state <= S_SEND;
            r_word  <= w_pad;
            r_idx   <= '0;
            r_data  <= f_chunk(w_pad, '0);
            r_last  <= (NCHUNK == 1);
            r_valid <= 1'b1;
        end else if (r_state == S_SEND) begin
            if (bus.abort || (w_xfer && r_last)) begin
                r_state <= S_IDLE;
                r_idx   <= '0;
                r_last  <= 1'b0;
                r_valid <= 1'b0;
            end else if (w_xfer) begin
                r_idx   <= w_next_idx;
                r_data  <= f_chunk(r_word, w_next_idx);
                r_last  <= (w_next_idx == LAST_IDX);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.out_last  = r_last;
    assign bus.out_idx   = r_idx;
    assign bus.busy      = r_valid;

endmodule

// File: tb/tb_word_chunk_serializer.sv
// Bench for word_chunk_serializer: three instances (LSB-first/left-justified,
// LSB-first/right-justified, MSB-first/left-justified) share one stimulus.
module tb_word_chunk_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [17:0] in_data;
    logic        out_ready;
    logic        abort;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    word_chunk_serializer_if #(.IN_W(18), .OUT_W(8)) ifa ();
    word_chunk_serializer_if #(.IN_W(18), .OUT_W(8)) ifb ();
    word_chunk_serializer_if #(.IN_W(18), .OUT_W(8)) ifc ();

    assign ifa.in_valid = in_valid;  assign ifa.in_data = in_data;
    assign ifa.out_ready = out_ready; assign ifa.abort = abort;
    assign ifb.in_valid = in_valid;  assign ifb.in_data = in_data;
    assign ifb.out_ready = out_ready; assign ifb.abort = abort;
    assign ifc.in_valid = in_valid;  assign ifc.in_data = in_data;
    assign ifc.out_ready = out_ready; assign ifc.abort = abort;

    word_chunk_serializer #(.IN_W(18), .OUT_W(8), .MSB_FIRST(0), .LAST_ALIGN(1))
        u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    word_chunk_serializer #(.IN_W(18), .OUT_W(8), .MSB_FIRST(0), .LAST_ALIGN(0))
        u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    word_chunk_serializer #(.IN_W(18), .OUT_W(8), .MSB_FIRST(1), .LAST_ALIGN(1))
        u_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    logic [2:0] ov, ir, bz, ol;
    logic [7:0] od [3];
    logic [1:0] oi [3];
    assign ov[0] = ifa.out_valid; assign ov[1] = ifb.out_valid; assign ov[2] = ifc.out_valid;
    assign ir[0] = ifa.in_ready;  assign ir[1] = ifb.in_ready;  assign ir[2] = ifc.in_ready;
    assign bz[0] = ifa.busy;      assign bz[1] = ifb.busy;      assign bz[2] = ifc.busy;
    assign ol[0] = ifa.out_last;  assign ol[1] = ifb.out_last;  assign ol[2] = ifc.out_last;
    assign od[0] = ifa.out_data;  assign od[1] = ifb.out_data;  assign od[2] = ifc.out_data;
    assign oi[0] = ifa.out_idx;   assign oi[1] = ifb.out_idx;   assign oi[2] = ifc.out_idx;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic [1:0] idx;
    } exp_t;

    exp_t q [3][$];

    // Reference chunk: full bytes come from shifting the word; the 2-bit
    // top remainder sits in the MSBs (la=1) or LSBs (la=0).
    function automatic logic [7:0] m_chunk(input logic [17:0] w, input int k,
                                           input bit msb, input bit la);
        int          p;
        logic [17:0] s;
        logic [1:0]  t;
        p = msb ? (2 - k) : k;
        if (p < 2) begin
            s = w >> (8 * p);
            return s[7:0];
        end
        t = w[17:16];
        return la ? {t, 6'b000000} : {6'b000000, t};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Scoreboard: inputs are stable from posedge+1 to the next posedge, so at
    // the negedge the upcoming accept/transfer/abort is already decided.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 3; i++) begin
                if (abort && bz[i]) begin
                    q[i].delete();
                end else if (ov[i] && out_ready) begin
                    checks++;
                    assert (q[i].size() != 0) else begin
                        failures++;
                        $error("FAIL sb_unexpected[%0d] observed=%0h expected=none", i, od[i]);
                    end
                    if (q[i].size() != 0) begin
                        exp_t e;
                        e = q[i].pop_front();
                        check($sformatf("sb_data[%0d]", i), 32'(od[i]), 32'(e.d));
                        check($sformatf("sb_last[%0d]", i), 32'(ol[i]), 32'(e.last));
                        check($sformatf("sb_idx[%0d]", i),  32'(oi[i]), 32'(e.idx));
                    end
                end
                if (in_valid && ir[i]) begin
                    for (int k = 0; k < 3; k++) begin
                        exp_t n;
                        n.d    = m_chunk(in_data, k, (i == 2), (i != 1));
                        n.last = (k == 2);
                        n.idx  = 2'(k);
                        q[i].push_back(n);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [7:0] d, input logic [1:0] idx,
                         input logic last);
        check({tag, "_valid"}, 32'(ifa.out_valid), 32'd1);
        check({tag, "_data"},  32'(ifa.out_data),  32'(d));
        check({tag, "_idx"},   32'(ifa.out_idx),   32'(idx));
        check({tag, "_last"},  32'(ifa.out_last),  32'(last));
    endtask

    logic [7:0] b2b [6];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; abort = 1'b0;
        tick(); tick();
        check("rst_valid", 32'(ifa.out_valid), 32'd0);
        check("rst_data",  32'(ifa.out_data),  32'd0);
        check("rst_last",  32'(ifa.out_last),  32'd0);
        check("rst_idx",   32'(ifa.out_idx),   32'd0);
        check("rst_busy",  32'(ifa.busy),      32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(ifa.in_ready), 32'd1);

        // Basic word, all three orderings/alignments.
        in_data = 18'h2A5C3; in_valid = 1'b1; out_ready = 1'b1;
        tick(); in_valid = 1'b0;
        chk_a("t1_c0", 8'hC3, 2'd0, 1'b0);
        check("t1_b_c0", 32'(ifb.out_data), 32'h0C3);
        check("t1_c_c0", 32'(ifc.out_data), 32'h080);
        tick();
        chk_a("t1_c1", 8'hA5, 2'd1, 1'b0);
        check("t1_in_ready_mid", 32'(ifa.in_ready), 32'd0);
        tick();
        chk_a("t1_c2", 8'h80, 2'd2, 1'b1);
        check("t1_b_c2", 32'(ifb.out_data), 32'h002);
        check("t1_c_c2", 32'(ifc.out_data), 32'h0C3);
        check("t1_c_last", 32'(ifc.out_last), 32'd1);
        check("t1_in_ready_last", 32'(ifa.in_ready), 32'd1);
        tick();
        check("t1_idle_valid", 32'(ifa.out_valid), 32'd0);
        check("t1_idle_busy",  32'(ifa.busy),      32'd0);

        // Back-to-back words with in_valid held.
        b2b = '{8'hFF, 8'hFF, 8'hC0, 8'h01, 8'h00, 8'h00};
        in_data = 18'h3FFFF; in_valid = 1'b1;
        tick(); in_data = 18'h00001;
        for (int j = 0; j < 6; j++) begin
            if (j > 0) tick();
            if (j == 3) in_valid = 1'b0;
            chk_a($sformatf("b2b_%0d", j), b2b[j], 2'(j % 3), (j % 3) == 2);
        end
        tick();
        check("b2b_idle", 32'(ifa.out_valid), 32'd0);

        // Backpressure during chunk 1.
        in_data = 18'h2A5C3; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        tick(); out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk_a($sformatf("bp_%0d", j), 8'hA5, 2'd1, 1'b0);
            check($sformatf("bp_in_ready_%0d", j), 32'(ifa.in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk_a("bp_resume", 8'h80, 2'd2, 1'b1);
        tick();

        // Abort while chunk 1 is offered; a word offered alongside is refused.
        in_data = 18'h2A5C3; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        tick();
        abort = 1'b1; in_valid = 1'b1; in_data = 18'h12345;
        check("abort_in_ready", 32'(ifa.in_ready), 32'd0);
        tick(); abort = 1'b0;
        check("abort_valid",    32'(ifa.out_valid), 32'd0);
        check("abort_busy",     32'(ifa.busy),      32'd0);
        check("abort_idx",      32'(ifa.out_idx),   32'd0);
        check("abort_in_ready_after", 32'(ifa.in_ready), 32'd1);
        tick(); in_valid = 1'b0;
        chk_a("abort_next_c0", 8'h45, 2'd0, 1'b0);
        tick(); tick(); tick();

        // Abort while idle does not block a word offered the same cycle.
        abort = 1'b1; in_valid = 1'b1; in_data = 18'h00001;
        tick(); abort = 1'b0; in_valid = 1'b0;
        chk_a("idle_abort_c0", 8'h01, 2'd0, 1'b0);
        tick(); tick(); tick();

        // Asynchronous reset mid-word.
        in_data = 18'h3FFFF; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(ifa.out_valid), 32'd0);
        check("arst_busy",  32'(ifa.busy),      32'd0);
        check("arst_data",  32'(ifa.out_data),  32'd0);
        for (int i = 0; i < 3; i++) q[i].delete();
        tick(); rst_n = 1'b1;
        in_data = 18'h12345; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk_a("arst_c0", 8'h45, 2'd0, 1'b0);
        tick();
        chk_a("arst_c1", 8'h23, 2'd1, 1'b0);
        tick();
        chk_a("arst_c2", 8'h40, 2'd2, 1'b1);
        tick(); tick();

        for (int i = 0; i < 3; i++)
            check($sformatf("sb_drained[%0d]", i), 32'(q[i].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/word_chunk_serializer.md
Name: word_chunk_serializer

Overview:
Parametrised width-down converter that accepts one IN_W-bit word and emits it as NCHUNK consecutive OUT_W-bit chunks. Both sides use valid/ready handshakes, and back-to-back words pass without a bubble. It generalises the fixed 18-to-8 three-cycle read path. It adds selectable chunk order, partial-chunk alignment, backpressure and abort. It sits between the memory read port and the byte-wide output stream.

Parameters:
IN_W, 18, input word width (>=1)
OUT_W, 8, output chunk width (1..IN_W)
MSB_FIRST, 0, 0 = least-significant chunk first; 1 = most-significant chunk first
LAST_ALIGN, 1, partial top chunk placement: 1 = left-justified (data in MSBs, zero-filled LSBs); 0 = right-justified (zero-filled MSBs)
(derived) NCHUNK = ceil(IN_W/OUT_W); IW = max(1, clog2(NCHUNK))

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_data valid
in_ready  out  1  block can accept a word this cycle
in_data  in  IN_W  word to serialise
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts chunk
out_data  out  OUT_W  current chunk
out_last  out  1  current chunk is the final chunk of the word
out_idx  out  IW  position of current chunk in emission order, 0..NCHUNK-1
abort  in  1  synchronous: drop the word being serialised
busy  out  1  a word is held (out_valid=1)

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_last=0, out_idx=0, busy=0. Holding register is cleared. in_ready=1 one cycle after release.
- States: IDLE (no word held), SEND (word held, chunk out_idx presented).
- in_ready = !busy || (out_valid && out_ready && out_last && !abort). This is combinational, so a new word can load on the same edge the last chunk leaves (zero-bubble).
- Accept at edge when in_valid && in_ready: the word is latched, chunk counter=0, and out_valid=1 from the next cycle. Latency is 1 cycle from accept to first chunk.
- Chunk k (emission index k):
  - For MSB_FIRST=0, physical chunk p=k; for MSB_FIRST=1, p=NCHUNK-1-k.
  - Physical chunk p = in_data[p*OUT_W +: OUT_W].
  - Top partial chunk (IN_W mod OUT_W = r != 0, p=NCHUNK-1): r valid bits, placed per LAST_ALIGN, remaining bits 0.
- out_data, out_last and out_idx are registered and stable while out_valid && !out_ready. No change is allowed under backpressure.
- Transfer = out_valid && out_ready. On transfer with !out_last, counter+1. On transfer with out_last, the counter returns to 0, and the block either goes to IDLE or loads a simultaneously accepted word (stays SEND).
- out_last = (counter == NCHUNK-1). When NCHUNK=1, every chunk is last.
- abort (SEND): takes priority over out_ready. At the next edge out_valid=0, out_idx=0 and the state is IDLE, whether or not a transfer was presented. A word offered in the abort cycle is not accepted, because in_ready is low unless the block is IDLE.
- abort in IDLE has no effect. in_valid accepted in IDLE in the same cycle as abort is loaded normally.
- in_valid while busy and not on the last-chunk transfer is ignored (in_ready=0). The upstream holds its data.
- Reset asserted mid-word discards the word immediately, with outputs at reset values asynchronously.
- in_data is sampled only at accept. Later changes do not affect the chunks in flight.

Test Plan:
- Defaults, accept 0x2A5C3 with out_ready=1 -> out_data 0xC3, 0xA5, 0x80 on 3 consecutive cycles; out_idx 0,1,2; out_last only with 0x80; in_ready high on the third chunk.
- LAST_ALIGN=0, same word -> 0xC3, 0xA5, 0x02. MSB_FIRST=1, LAST_ALIGN=1 -> 0x80, 0xA5, 0xC3 with out_last on 0xC3.
- Back-to-back words 0x3FFFF then 0x00001, in_valid held, out_ready=1 -> 6 contiguous chunks FF,FF,C0,01,00,00 with no idle cycle between words.
- Backpressure: out_ready low for 4 cycles during chunk 1 -> out_data=0xA5 and out_idx=1 stable throughout; in_ready=0; emission resumes unchanged.
- Abort asserted with chunk 1 valid and out_ready=1 -> next cycle out_valid=0, busy=0, in_ready=1; the next word starts at out_idx=0.
- rst_n pulsed low mid-word -> out_valid falls without a clock; after release, a fresh accept of 0x12345 yields 0x45, 0x23, 0x40.
